serial_bridge: RTL and testbench
================================

SERIAL_BRIDGE -- requirements
Module: serial_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entries per FIFO (power of two, >=2).
REQ-002 SHALL have port clk  input  1  CPU/UART clock (11.0592 MHz domain).
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ce_i  input  1  CPU serial-space access strobe.
REQ-005 SHALL have port we_i  input  1  1=write, 0=read.
REQ-006 SHALL have port addr_i  input  4  byte offset: 0x0 DATA, 0x4 STATUS.
REQ-007 SHALL have port sel_i  input  4  byte enables.
REQ-008 SHALL have port data_i  input  32  CPU write data.
REQ-009 SHALL have port data_o  output  32  CPU read data.
REQ-010 SHALL have port tx_start_o  output  1  transmitter start pulse.
REQ-011 SHALL have port tx_data_o  output  8  byte to transmit.
REQ-012 SHALL have port tx_busy_i  input  1  transmitter busy.
REQ-013 SHALL have port rx_ready_i  input  1  receiver one-cycle byte-valid pulse.
REQ-014 SHALL have port rx_data_i  input  8  received byte.
REQ-015 SHALL have port int_o  output  1  RX interrupt request.

Function
REQ-016 SHALL hold a TX FIFO and an RX FIFO, each DEPTH x 8, with occupancy counters of width log2(DEPTH)+1.
REQ-017 DATA write (ce_i, we_i, addr_i=0x0, sel_i[0]) SHALL push data_i[7:0] into TX FIFO at the clock edge; sel_i[0]=0 SHALL be ignored.
REQ-018 TX push while full SHALL drop the byte and set sticky TXOVF.
REQ-019 DATA read SHALL return {24'b0, RX head} combinationally in the same cycle and pop at the edge; empty RX SHALL return 0 with no pop.
REQ-020 Each cycle with an active DATA read SHALL pop exactly once.
REQ-021 STATUS read SHALL return bit0 TX not full, bit1 RX not empty, bit2 TXOVF, bit3 RXOVF, bit4 TX idle (FIFO empty and FSM IDLE), bits[31:5]=0.
REQ-022 STATUS write SHALL clear TXOVF/RXOVF where data_i bit2/bit3 = 1 (write-one-to-clear); other bits ignored.
REQ-023 Accesses to any other offset SHALL read 0 and have no effect.
REQ-024 rx_ready_i=1 SHALL push rx_data_i; push while full SHALL drop it and set RXOVF.
REQ-025 Simultaneous push and pop on the same FIFO SHALL both occur; occupancy unchanged; a full FIFO SHALL accept a push in the same cycle as a pop.
REQ-026 TX FSM states IDLE, LOAD, GUARD, DRAIN.
REQ-027 IDLE -> LOAD when TX FIFO not empty and tx_busy_i=0.
REQ-028 LOAD: tx_start_o=1 for exactly one cycle, tx_data_o=TX head, pop TX; -> GUARD.
REQ-029 GUARD: one cycle, tx_start_o=0; -> DRAIN.
REQ-030 DRAIN: -> IDLE when tx_busy_i=0.
REQ-031 tx_data_o SHALL hold the last launched byte outside LOAD.
REQ-032 Pointers SHALL wrap modulo DEPTH.

Reset
REQ-033 rst=0 SHALL asynchronously empty both FIFOs, clear TXOVF/RXOVF, force FSM IDLE, tx_start_o=0, tx_data_o=0, int_o=0.
REQ-034 Reset asserted mid-transfer SHALL abort the FSM; the byte in flight is lost; no further start pulse until a new push.
REQ-035 data_o SHALL equal 0 while in reset.

Configuration
REQ-036 With SERIAL_BRIDGE_INT_EN defined, int_o SHALL be registered RX-not-empty OR RXOVF (one cycle latency).
REQ-037 Without SERIAL_BRIDGE_INT_EN, int_o SHALL be constant 0 and no interrupt logic SHALL be generated.

Verification
REQ-038 Write 0x41 to DATA, tx_busy_i idle -> one tx_start_o pulse with tx_data_o=0x41 two cycles after write; STATUS bit4=1 after busy falls.
REQ-039 DEPTH=8, tx_busy_i held 1, write 9 bytes 0x00..0x08 -> STATUS bit0=0, bit2=1; release busy -> exactly 0x00..0x07 transmitted in order.
REQ-040 Pulse rx_ready_i with 0x5A, 0xA5 -> DATA reads return 0x5A, 0xA5, then 0x00; STATUS bit1 1,1,0.
REQ-041 RX FIFO full, rx_ready_i and DATA read same cycle -> read returns old head, new byte stored, RXOVF stays 0.
REQ-042 Set TXOVF and RXOVF, write 0x4 to STATUS -> only TXOVF clears; write 0x8 -> RXOVF clears.
REQ-043 rst=0 during DRAIN with 3 bytes queued -> FIFOs empty, STATUS=0x11, no tx_start_o after release; with SERIAL_BRIDGE_INT_EN, RX push -> int_o=1 next cycle.

Source files
------------

// File: rtl/serial_bridge.sv
// serial_bridge: CPU-facing bridge between a 32-bit register port and a byte UART.
// A TX FIFO feeds a small launch FSM that pulses tx_start_o toward the transmitter.
// An RX FIFO collects bytes from the receiver for the CPU to read.
// Register map: 0x0 DATA (write = TX push, read = RX pop), 0x4 STATUS (read, W1C overflow).
// Optional feature: define SERIAL_BRIDGE_INT_EN to build the RX interrupt output.
module serial_bridge #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [3:0]  addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        tx_start_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_busy_i,
  input  logic        rx_ready_i,
  input  logic [7:0]  rx_data_i,
  output logic        int_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, GUARD, DRAIN} tx_state_t;

  tx_state_t       state;
  logic [7:0]      tx_mem [DEPTH];
  logic [7:0]      rx_mem [DEPTH];
  logic [AW-1:0]   tx_wr, tx_rd, rx_wr, rx_rd;
  logic [CW-1:0]   tx_cnt, rx_cnt;
  logic            tx_ovf, rx_ovf;

  logic is_data, is_stat;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push_req, tx_push, tx_pop, tx_ovf_set;
  logic rx_pop, rx_push, rx_ovf_set;
  logic stat_wr, tx_idle;
  logic unused_bits;

  assign is_data  = (addr_i == 4'h0);
  assign is_stat  = (addr_i == 4'h4);
  assign tx_full  = (tx_cnt == FULL_CNT);
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == FULL_CNT);
  assign rx_empty = (rx_cnt == '0);

  // TX side: the FSM pops while in LOAD, so a full FIFO may still take a push that cycle
  assign tx_push_req = ce_i & we_i & is_data & sel_i[0];
  assign tx_pop      = (state == LOAD);
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);
  assign tx_ovf_set  = tx_push_req & tx_full & ~tx_pop;

  // RX side: a CPU DATA read on a non-empty FIFO pops once per cycle
  assign rx_pop      = ce_i & ~we_i & is_data & ~rx_empty;
  assign rx_push     = rx_ready_i & (~rx_full | rx_pop);
  assign rx_ovf_set  = rx_ready_i & rx_full & ~rx_pop;

  assign stat_wr     = ce_i & we_i & is_stat;
  assign tx_idle     = tx_empty & (state == IDLE);

  // Upper write-data and byte-enable bits carry no meaning in this register map
  assign unused_bits = ^{sel_i[3:1], data_i[31:8]};

  // FIFO storage; emptiness is tracked by the counters, so no reset is needed here
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= data_i[7:0];
    if (rx_push) rx_mem[rx_wr] <= rx_data_i;
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // Sticky overflow flags; a new overflow wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
    end else begin
      if (tx_ovf_set)                tx_ovf <= 1'b1;
      else if (stat_wr && data_i[2]) tx_ovf <= 1'b0;
      if (rx_ovf_set)                rx_ovf <= 1'b1;
      else if (stat_wr && data_i[3]) rx_ovf <= 1'b0;
    end
  end

  // Launch FSM: start pulse and byte are registered on entry to LOAD
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tx_start_o <= 1'b0;
      tx_data_o  <= 8'h00;
    end else begin
      tx_start_o <= 1'b0;
      case (state)
        IDLE: if (!tx_empty && !tx_busy_i) begin
          state      <= LOAD;
          tx_start_o <= 1'b1;
          tx_data_o  <= tx_mem[tx_rd];
        end
        LOAD:    state <= GUARD;
        GUARD:   state <= DRAIN;
        DRAIN:   if (!tx_busy_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // CPU read mux; forced to zero while reset is held
  always_comb begin
    data_o = 32'h0;
    if (rst && ce_i && !we_i) begin
      if (is_data && !rx_empty) data_o = {24'h0, rx_mem[rx_rd]};
      else if (is_stat)         data_o = {27'h0, tx_idle, rx_ovf, tx_ovf, ~rx_empty, ~tx_full};
    end
  end

`ifdef SERIAL_BRIDGE_INT_EN
  logic int_q;
  // Interrupt request: RX data pending or RX overflow, one cycle behind the flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) int_q <= 1'b0;
    else      int_q <= ~rx_empty | rx_ovf;
  end
  assign int_o = int_q;
`else
  assign int_o = 1'b0;
`endif

endmodule

// File: tb/tb_serial_bridge.sv
// Directed self-checking bench for serial_bridge (DEPTH = 8).
module tb_serial_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce_i = 1'b0, we_i = 1'b0;
  logic [3:0]  addr_i = 4'h0, sel_i = 4'h0;
  logic [31:0] data_i = 32'h0;
  logic [31:0] data_o;
  logic        tx_start_o;
  logic [7:0]  tx_data_o;
  logic        tx_busy_i = 1'b0;
  logic        rx_ready_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h0;
  logic        int_o;

  int tests  = 0;
  int failed = 0;
  logic [7:0] txlog [$];

  serial_bridge #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i), .sel_i(sel_i),
    .data_i(data_i), .data_o(data_o), .tx_start_o(tx_start_o), .tx_data_o(tx_data_o),
    .tx_busy_i(tx_busy_i), .rx_ready_i(rx_ready_i), .rx_data_i(rx_data_i), .int_o(int_o)
  );

  always #5 clk = ~clk;

  // record every launched byte; the pulse spans a whole cycle so one negedge sees it once
  always @(negedge clk) if (tx_start_o) txlog.push_back(tx_data_o);

  task automatic cpu_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    ce_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d; sel_i = s;
    @(posedge clk); #1;
    ce_i = 1'b0; we_i = 1'b0; sel_i = 4'h0;
  endtask

  task automatic cpu_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    ce_i = 1'b1; we_i = 1'b0; addr_i = a;
    #1 d = data_o;
    @(posedge clk); #1;
    ce_i = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    @(negedge clk);
    rx_ready_i = 1'b1; rx_data_i = b;
    @(posedge clk); #1;
    rx_ready_i = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    @(negedge clk);
    rst = 1'b0; ce_i = 1'b1; we_i = 1'b0; addr_i = 4'h4;
    #1;
    tests++; if (data_o !== 32'h0) begin failed++; $display("FAIL reset_data_o got %h want 0", data_o); end
    tests++; if ({tx_start_o, tx_data_o, int_o} !== 10'h0) begin failed++;
      $display("FAIL reset_outputs got start=%b data=%h int=%b want 0", tx_start_o, tx_data_o, int_o); end
    ce_i = 1'b0;
    @(negedge clk); rst = 1'b1;
    cpu_rd(4'h4, d);
    tests++; if (d !== 32'h11) begin failed++; $display("FAIL reset_status got %h want 11", d); end
  endtask

  task automatic test_tx_single;
    logic [31:0] d;
    txlog.delete();
    cpu_wr(4'h0, 32'h41, 4'h1);
    @(negedge clk);
    tests++; if (tx_start_o !== 1'b0) begin failed++; $display("FAIL tx1_early_start got %b want 0", tx_start_o); end
    @(negedge clk);
    tests++; if (tx_start_o !== 1'b1 || tx_data_o !== 8'h41) begin failed++;
      $display("FAIL tx1_pulse got start=%b data=%h want 1/41", tx_start_o, tx_data_o); end
    @(negedge clk);
    tests++; if (tx_start_o !== 1'b0) begin failed++; $display("FAIL tx1_pulse_width got %b want 0", tx_start_o); end
    repeat (4) @(negedge clk);
    cpu_rd(4'h4, d);
    tests++; if (d !== 32'h11) begin failed++; $display("FAIL tx1_idle_status got %h want 11", d); end
    tests++; if (txlog.size() !== 1 || tx_data_o !== 8'h41) begin failed++;
      $display("FAIL tx1_count got %0d pulses hold=%h want 1/41", txlog.size(), tx_data_o); end
  endtask

  task automatic test_sel_ignore;
    logic [31:0] d;
    txlog.delete();
    cpu_wr(4'h0, 32'h77, 4'b1110);
    cpu_wr(4'h8, 32'h66, 4'hF);
    repeat (6) @(negedge clk);
    cpu_rd(4'h4, d);
    tests++; if (d !== 32'h11 || txlog.size() !== 0) begin failed++;
      $display("FAIL sel_ignore got status=%h pulses=%0d want 11/0", d, txlog.size()); end
    cpu_rd(4'hC, d);
    tests++; if (d !== 32'h0) begin failed++; $display("FAIL other_offset_read got %h want 0", d); end
  endtask

  task automatic test_tx_overflow;
    logic [31:0] d;
    txlog.delete();
    tx_busy_i = 1'b1;
    for (int i = 0; i < 9; i++) cpu_wr(4'h0, i, 4'h1);
    cpu_rd(4'h4, d);
    tests++; if (d !== 32'h04) begin failed++; $display("FAIL txovf_status got %h want 04", d); end
    tx_busy_i = 1'b0;
    for (int i = 0; i < 200 && txlog.size() < 8; i++) @(negedge clk);
    repeat (12) @(negedge clk);
    tests++; if (txlog.size() !== 8) begin failed++; $display("FAIL txovf_count got %0d want 8", txlog.size()); end
    for (int i = 0; i < 8 && i < txlog.size(); i++) begin
      tests++; if (txlog[i] !== 8'(i)) begin failed++; $display("FAIL txovf_order[%0d] got %h want %h", i, txlog[i], 8'(i)); end
    end
    cpu_rd(4'h4, d);
    tests++; if (d !== 32'h15) begin failed++; $display("FAIL txovf_drained got %h want 15", d); end
    cpu_wr(4'h4, 32'h4, 4'h1);
    cpu_rd(4'h4, d);
    tests++; if (d !== 32'h11) begin failed++; $display("FAIL txovf_clear got %h want 11", d); end
  endtask

  task automatic test_rx_basic;
    logic [31:0] d;
    logic [31:0] exp_s [6];
    logic [31:0] exp_d [3];
    exp_s = '{32'h13, 32'h0, 32'h13, 32'h0, 32'h11, 32'h0};
    exp_d = '{32'h5A, 32'hA5, 32'h00};
    rx_pulse(8'h5A);
    rx_pulse(8'hA5);
    for (int i = 0; i < 3; i++) begin
      cpu_rd(4'h4, d);
      tests++; if (d !== exp_s[2*i]) begin failed++; $display("FAIL rx_status[%0d] got %h want %h", i, d, exp_s[2*i]); end
      cpu_rd(4'h0, d);
      tests++; if (d !== exp_d[i]) begin failed++; $display("FAIL rx_data[%0d] got %h want %h", i, d, exp_d[i]); end
    end
  endtask

  task automatic test_rx_full_simul;
    logic [31:0] d;
    for (int i = 0; i < 8; i++) rx_pulse(8'h10 + 8'(i));
    @(negedge clk);
    ce_i = 1'b1; we_i = 1'b0; addr_i = 4'h0; rx_ready_i = 1'b1; rx_data_i = 8'h99;
    #1 d = data_o;
    @(posedge clk); #1;
    ce_i = 1'b0; rx_ready_i = 1'b0;
    tests++; if (d !== 32'h10) begin failed++; $display("FAIL rxsim_head got %h want 10", d); end
    cpu_rd(4'h4, d);
    tests++; if (d !== 32'h13) begin failed++; $display("FAIL rxsim_status got %h want 13", d); end
    for (int i = 0; i < 8; i++) begin
      logic [31:0] e;
      e = (i == 7) ? 32'h99 : 32'h11 + i;
      cpu_rd(4'h0, d);
      tests++; if (d !== e) begin failed++; $display("FAIL rxsim_drain[%0d] got %h want %h", i, d, e); end
    end
    for (int i = 0; i < 9; i++) rx_pulse(8'hC0 + 8'(i));
    cpu_rd(4'h4, d);
    tests++; if (d !== 32'h1B) begin failed++; $display("FAIL rxovf_status got %h want 1B", d); end
  endtask

  task automatic test_ovf_clear;
    logic [31:0] d;
    tx_busy_i = 1'b1;
    for (int i = 0; i < 9; i++) cpu_wr(4'h0, 32'hE0 + i, 4'h1);
    cpu_rd(4'h4, d);
    tests++; if (d !== 32'h0E) begin failed++; $display("FAIL both_ovf got %h want 0E", d); end
    cpu_wr(4'h4, 32'h4, 4'h1);
    cpu_rd(4'h4, d);
    tests++; if (d !== 32'h0A) begin failed++; $display("FAIL clear_txovf got %h want 0A", d); end
    cpu_wr(4'h4, 32'h8, 4'h1);
    cpu_rd(4'h4, d);
    tests++; if (d !== 32'h02) begin failed++; $display("FAIL clear_rxovf got %h want 02", d); end
  endtask

  task automatic test_reset_mid_transfer;
    logic [31:0] d;
    @(negedge clk); rst = 1'b0; tx_busy_i = 1'b0;
    @(negedge clk); rst = 1'b1;
    txlog.delete();
    for (int i = 0; i < 4; i++) cpu_wr(4'h0, 32'hB0 + i, 4'h1);
    tx_busy_i = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (txlog.size() !== 1 || (txlog.size() > 0 && txlog[0] !== 8'hB0)) begin failed++;
      $display("FAIL mid_first_launch got %0d pulses want 1 of B0", txlog.size()); end
    txlog.delete();
    @(negedge clk);
    rst = 1'b0; ce_i = 1'b1; we_i = 1'b0; addr_i = 4'h4;
    #1;
    tests++; if (data_o !== 32'h0 || tx_start_o !== 1'b0) begin failed++;
      $display("FAIL mid_in_reset got data=%h start=%b want 0/0", data_o, tx_start_o); end
    ce_i = 1'b0;
    @(negedge clk); rst = 1'b1; tx_busy_i = 1'b0;
    repeat (20) @(negedge clk);
    tests++; if (txlog.size() !== 0) begin failed++; $display("FAIL mid_no_restart got %0d pulses want 0", txlog.size()); end
    cpu_rd(4'h4, d);
    tests++; if (d !== 32'h11) begin failed++; $display("FAIL mid_status got %h want 11", d); end
  endtask

  task automatic test_interrupt;
    tests++; if (int_o !== 1'b0) begin failed++; $display("FAIL int_idle got %b want 0", int_o); end
    rx_pulse(8'h3C);
    @(negedge clk);
    @(negedge clk);
`ifdef SERIAL_BRIDGE_INT_EN
    tests++; if (int_o !== 1'b1) begin failed++; $display("FAIL int_after_push got %b want 1", int_o); end
`else
    tests++; if (int_o !== 1'b0) begin failed++; $display("FAIL int_disabled got %b want 0", int_o); end
`endif
  endtask

  initial begin
    test_reset;
    test_tx_single;
    test_sel_ignore;
    test_tx_overflow;
    test_rx_basic;
    test_rx_full_simul;
    test_ovf_clear;
    test_reset_mid_transfer;
    test_interrupt;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
